// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the NPC pipeline hazard scheduler: FSM encoding, the bundle
// of per-register stall/flush controls, and the canned control patterns.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int MC_MAX_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_REDIR   = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic flush_wb;
    logic redir_take;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Whole pipe holds while MEM waits; WB gets a bubble so nothing retires twice.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c           = CTRL_IDLE;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_ex  = 1'b1;
    c.stall_mem = 1'b1;
    c.flush_wb  = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_mc_hold();
    ctrl_t c;
    c           = CTRL_IDLE;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_ex  = 1'b1;
    c.flush_mem = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_redirect();
    ctrl_t c;
    c            = CTRL_IDLE;
    c.redir_take = 1'b1;
    c.flush_id   = 1'b1;
    c.flush_ex   = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_squash_fetch();
    ctrl_t c;
    c          = CTRL_IDLE;
    c.flush_id = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c          = CTRL_IDLE;
    c.stall_if = 1'b1;
    c.stall_id = 1'b1;
    c.flush_ex = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Purely combinational.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RegAddrW = REG_ADDR_W
) (
  input  logic                i_id_valid,
  input  logic [RegAddrW-1:0] i_id_rs1,
  input  logic [RegAddrW-1:0] i_id_rs2,
  input  logic                i_id_rs1_used,
  input  logic                i_id_rs2_used,
  input  logic                i_ex_valid,
  input  logic [RegAddrW-1:0] i_ex_rd,
  input  logic                i_ex_wen,
  input  logic                i_ex_is_load,
  output logic                o_load_use
);

  logic w_ex_load_producer;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_ex_load_producer = i_ex_valid & i_ex_is_load & i_ex_wen &
                              (i_ex_rd != '0);

  assign w_rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);

  assign o_load_use = w_ex_load_producer & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline: mem freeze, multi-cycle
// EX hold, two-cycle redirect squash and load-use bubble, plus an MC watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RegAddrW    = REG_ADDR_W,
  parameter int McMaxCycles = MC_MAX_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [RegAddrW-1:0] id_rs1,
  input  logic [RegAddrW-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                ex_valid,
  input  logic [RegAddrW-1:0] ex_rd,
  input  logic                ex_wen,
  input  logic                ex_is_load,
  input  logic                ex_mc_start,
  input  logic                ex_mc_done,
  input  logic                ex_redirect,
  input  logic                mem_busy,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                stall_mem,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                flush_mem,
  output logic                flush_wb,
  output logic                redir_take,
  output logic                mc_timeout,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(McMaxCycles + 1);
  localparam logic [CNT_W-1:0] MC_LIMIT = CNT_W'(McMaxCycles);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_mc_cnt;
  logic             r_mc_timeout;
  logic             w_load_use;
  logic             w_mc_enter;
  logic             w_mc_new;
  logic             w_redirect_new;
  ctrl_t            w_ctrl;

  hazard_detect #(
    .RegAddrW (RegAddrW)
  ) u_hazard_detect (
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rs1_used (id_rs1_used),
    .i_id_rs2_used (id_rs2_used),
    .i_ex_valid    (ex_valid),
    .i_ex_rd       (ex_rd),
    .i_ex_wen      (ex_wen),
    .i_ex_is_load  (ex_is_load),
    .o_load_use    (w_load_use)
  );

  // A start that completes in the same cycle behaves like a single-cycle op.
  assign w_mc_new       = ex_valid & ex_mc_start & ~ex_mc_done;
  assign w_redirect_new = ex_valid & ex_redirect;

  always_comb begin
    w_ctrl      = CTRL_IDLE;
    w_state_nxt = r_state;
    w_mc_enter  = 1'b0;
    if (mem_busy) begin
      w_ctrl = ctrl_freeze();
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_mc_new) begin
            w_ctrl      = ctrl_mc_hold();
            w_state_nxt = ST_MC_WAIT;
            w_mc_enter  = 1'b1;
          end else if (w_redirect_new) begin
            w_ctrl      = ctrl_redirect();
            w_state_nxt = ST_REDIR;
          end else if (w_load_use) begin
            w_ctrl = ctrl_load_use();
          end
        end
        ST_MC_WAIT: begin
          if (ex_mc_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl = ctrl_mc_hold();
          end
        end
        ST_REDIR: begin
          // EX holds a bubble here, so ex_redirect is stale and ignored.
          w_ctrl      = ctrl_squash_fetch();
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter keeps running through a mem freeze; it saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mc_cnt <= '0;
    end else if (w_mc_enter) begin
      r_mc_cnt <= '0;
    end else if ((r_state == ST_MC_WAIT) && (r_mc_cnt != MC_LIMIT)) begin
      r_mc_cnt <= r_mc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mc_timeout <= 1'b0;
    end else if ((r_state == ST_MC_WAIT) && (r_mc_cnt == MC_LIMIT - 1'b1)) begin
      r_mc_timeout <= 1'b1;
    end
  end

  // Controls are forced low the moment reset asserts, independent of inputs.
  assign stall_if   = rst & w_ctrl.stall_if;
  assign stall_id   = rst & w_ctrl.stall_id;
  assign stall_ex   = rst & w_ctrl.stall_ex;
  assign stall_mem  = rst & w_ctrl.stall_mem;
  assign flush_id   = rst & w_ctrl.flush_id;
  assign flush_ex   = rst & w_ctrl.flush_ex;
  assign flush_mem  = rst & w_ctrl.flush_mem;
  assign flush_wb   = rst & w_ctrl.flush_wb;
  assign redir_take = rst & w_ctrl.redir_take;
  assign mc_timeout = r_mc_timeout;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int AW    = 5;
  localparam int MCMAX = 8;
  localparam int VW    = 12;

  // Vector layout: {si,sd,se,sm, fi,fe,fm,fw, rt,timeout,state[1:0]}
  localparam logic [VW-1:0] V_IDLE     = 12'b0000_0000_0000;
  localparam logic [VW-1:0] V_LOADUSE  = 12'b1100_0100_0000;
  localparam logic [VW-1:0] V_MC_RUN   = 12'b1110_0010_0000;
  localparam logic [VW-1:0] V_MC_WAIT  = 12'b1110_0010_0001;
  localparam logic [VW-1:0] V_MC_DONE  = 12'b0000_0000_0001;
  localparam logic [VW-1:0] V_MC_TOUT  = 12'b1110_0010_0101;
  localparam logic [VW-1:0] V_REDIR_N  = 12'b0000_1100_1000;
  localparam logic [VW-1:0] V_REDIR_N1 = 12'b0000_1000_0010;
  localparam logic [VW-1:0] V_FREEZE   = 12'b1111_0001_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic          ex_valid = 1'b0, ex_wen = 1'b0, ex_is_load = 1'b0;
  logic          ex_mc_start = 1'b0, ex_mc_done = 1'b0, ex_redirect = 1'b0;
  logic          mem_busy = 1'b0;

  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb, redir_take, mc_timeout;
  logic [1:0] dbg_state;

  pipe_ctrl #(.RegAddrW(AW), .McMaxCycles(MCMAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .redir_take(redir_take), .mc_timeout(mc_timeout), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q[$];

  function automatic logic [VW-1:0] dut_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
            flush_mem, flush_wb, redir_take, mc_timeout, dbg_state};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks what the pipeline is doing in plain terms: a long op occupying EX,
  // a pending stale-fetch squash, cycles spent waiting on the long op.
  logic m_in_mc, m_squash, m_timeout;
  int   m_mc_cycles;

  function automatic logic model_load_use();
    logic [AW-1:0] dst;
    dst = ex_rd;
    if (!(ex_valid && ex_is_load && ex_wen && id_valid) || dst == 0) return 1'b0;
    return (id_rs1_used && id_rs1 == dst) || (id_rs2_used && id_rs2 == dst);
  endfunction

  function automatic logic [VW-1:0] model_out();
    logic si, sd, se, sm, fi, fe, fm, fw, rt;
    logic [1:0] st;
    {si, sd, se, sm, fi, fe, fm, fw, rt} = '0;
    st = m_in_mc ? 2'd1 : (m_squash ? 2'd2 : 2'd0);
    if (!rst) return '0;
    if (mem_busy) begin
      {si, sd, se, sm, fw} = 5'b11111;
    end else if (m_in_mc) begin
      if (!ex_mc_done) {si, sd, se, fm} = 4'b1111;
    end else if (m_squash) begin
      fi = 1'b1;
    end else if (ex_valid && ex_mc_start && !ex_mc_done) begin
      {si, sd, se, fm} = 4'b1111;
    end else if (ex_valid && ex_redirect) begin
      {rt, fi, fe} = 3'b111;
    end else if (model_load_use()) begin
      {si, sd, fe} = 3'b111;
    end
    return {si, sd, se, sm, fi, fe, fm, fw, rt, m_timeout, st};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in_mc     <= 1'b0;
      m_squash    <= 1'b0;
      m_timeout   <= 1'b0;
      m_mc_cycles <= 0;
    end else begin
      if (m_in_mc) begin
        if (m_mc_cycles + 1 >= MCMAX) m_timeout <= 1'b1;
        m_mc_cycles <= m_mc_cycles + 1;
      end
      if (!mem_busy) begin
        if (m_in_mc) begin
          if (ex_mc_done) m_in_mc <= 1'b0;
        end else if (m_squash) begin
          m_squash <= 1'b0;
        end else if (ex_valid && ex_mc_start && !ex_mc_done) begin
          m_in_mc     <= 1'b1;
          m_mc_cycles <= 0;
        end else if (ex_valid && ex_redirect) begin
          m_squash <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    exp_q.push_back(model_out());
    check("model", dut_vec(), exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_rd = '0; ex_wen = 0; ex_is_load = 0;
    ex_mc_start = 0; ex_mc_done = 0; ex_redirect = 0; mem_busy = 0;
  endtask

  task automatic drive_load(input logic [AW-1:0] rd, input logic [AW-1:0] rs2);
    set_idle();
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = rd;
    id_valid = 1; id_rs2 = rs2; id_rs2_used = 1; id_rs1 = 5'd7; id_rs1_used = 1;
  endtask

  task automatic drive_random();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_rs1      = AW'($urandom_range(0, 3));
    id_rs2      = AW'($urandom_range(0, 3));
    id_rs1_used = $urandom_range(0, 1) == 1;
    id_rs2_used = $urandom_range(0, 1) == 1;
    ex_valid    = ($urandom_range(0, 4) != 0);
    ex_rd       = AW'($urandom_range(0, 3));
    ex_wen      = ($urandom_range(0, 3) != 0);
    ex_is_load  = ($urandom_range(0, 9) < 4);
    ex_mc_start = ($urandom_range(0, 99) < 12);
    ex_mc_done  = ($urandom_range(0, 9) < 3);
    ex_redirect = ($urandom_range(0, 99) < 15);
    mem_busy    = ($urandom_range(0, 99) < 15);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    ex_valid = 1; ex_redirect = 1; mem_busy = 1;
    #12;
    check("reset_outputs", dut_vec(), V_IDLE);
    set_idle();
    @(negedge clk);
    rst = 1;

    // load-use: one bubble, then clean
    next_cycle(); drive_load(5'd5, 5'd5);
    @(negedge clk); check("load_use", dut_vec(), V_LOADUSE);
    next_cycle(); set_idle();
    @(negedge clk); check("load_use_after", dut_vec(), V_IDLE);
    next_cycle(); drive_load(5'd0, 5'd0);
    @(negedge clk); check("load_use_x0", dut_vec(), V_IDLE);
    next_cycle(); drive_load(5'd5, 5'd5); ex_wen = 0;
    @(negedge clk); check("load_use_nowen", dut_vec(), V_IDLE);

    // multi-cycle op: done on the 4th EX cycle
    next_cycle(); set_idle(); ex_valid = 1; ex_mc_start = 1;
    @(negedge clk); check("mc_c1", dut_vec(), V_MC_RUN);
    next_cycle(); ex_mc_start = 0;
    @(negedge clk); check("mc_c2", dut_vec(), V_MC_WAIT);
    next_cycle();
    @(negedge clk); check("mc_c3", dut_vec(), V_MC_WAIT);
    next_cycle(); ex_mc_done = 1;
    @(negedge clk); check("mc_c4_done", dut_vec(), V_MC_DONE);
    next_cycle(); set_idle();
    @(negedge clk); check("mc_after", dut_vec(), V_IDLE);

    // start and done together: single-cycle, no stall
    next_cycle(); ex_valid = 1; ex_mc_start = 1; ex_mc_done = 1;
    @(negedge clk); check("mc_same_cycle", dut_vec(), V_IDLE);

    // redirect: two bubbles; ex_redirect held in N+1 must be ignored
    next_cycle(); set_idle(); ex_valid = 1; ex_redirect = 1;
    @(negedge clk); check("redir_n", dut_vec(), V_REDIR_N);
    next_cycle();
    @(negedge clk); check("redir_n1", dut_vec(), V_REDIR_N1);
    next_cycle(); set_idle();
    @(negedge clk); check("redir_n2", dut_vec(), V_IDLE);

    // mem freeze overlapping a redirect
    next_cycle(); ex_valid = 1; ex_redirect = 1; mem_busy = 1;
    @(negedge clk); check("freeze_c1", dut_vec(), V_FREEZE);
    next_cycle();
    @(negedge clk); check("freeze_c2", dut_vec(), V_FREEZE);
    next_cycle(); mem_busy = 0;
    @(negedge clk); check("freeze_redir", dut_vec(), V_REDIR_N);
    next_cycle(); ex_redirect = 0;
    @(negedge clk); check("freeze_redir_n1", dut_vec(), V_REDIR_N1);
    next_cycle(); set_idle();
    @(negedge clk); check("freeze_after", dut_vec(), V_IDLE);

    // watchdog: done never arrives
    next_cycle(); ex_valid = 1; ex_mc_start = 1;
    @(negedge clk); check("wd_start", dut_vec(), V_MC_RUN);
    next_cycle(); ex_mc_start = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); check("wd_wait", dut_vec(), V_MC_WAIT);
      next_cycle();
    end
    @(negedge clk); check("wd_8th_wait", dut_vec(), V_MC_WAIT);
    next_cycle();
    @(negedge clk); check("wd_timeout", dut_vec(), V_MC_TOUT);
    next_cycle();
    @(negedge clk); check("wd_sticky", dut_vec(), V_MC_TOUT);
    #2 rst = 0;
    #1 check("wd_async_reset", dut_vec(), V_IDLE);
    @(negedge clk); rst = 1;
    next_cycle(); set_idle();
    @(negedge clk); check("post_reset_idle", dut_vec(), V_IDLE);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (!rst) rst = 1;
      drive_random();
      if ($urandom_range(0, 299) == 0) rst = 0;
    end
    next_cycle(); set_idle(); rst = 1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
